// File: rtl/demux_1x4_5bit_reg.sv
// ---------------------------------------------------------------------------
// demux_1x4_5bit_reg
//
// Registered 1-to-4 demultiplexer. A single valid/ready input stream carries a
// WIDTH-bit value and a 2-bit destination index. Each accepted value is loaded
// into the one-entry holding register of the selected destination. Each of the
// four holding registers is drained by its own consumer through its own
// valid/ready handshake.
//
// Only in_ready is combinational. It depends on in_sel, the slot valid flags
// and out_ready, and never on in_valid. Every data output comes from a
// register, so there is no combinational path from in_data to any outk.
//
// Parameters
//   WIDTH       data width of the input and of every output slot
//   CNT_W       width of the accepted-transfer counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     value to route
//   in_sel      destination slot index 0..3
//   in_valid    in_data/in_sel are valid this cycle
//   in_ready    selected slot can take a value this cycle (combinational)
//   out0..out3  holding-register contents of each slot
//   out_valid   bit k set while slot k holds unconsumed data
//   out_ready   bit k: consumer k takes outk this cycle
//   busy        at least one slot holds unconsumed data
//   accept_cnt  running count of accepted input transfers, wraps
// ---------------------------------------------------------------------------
module demux_1x4_5bit_reg #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,

    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,

    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             acc;
    logic [3:0]       load;
    logic [3:0]       take;

    // -----------------------------------------------------------------------
    // Input handshake
    // -----------------------------------------------------------------------
    // Only the addressed slot can stall the producer. A full slot that is
    // drained in the same cycle can still accept a value, which gives
    // 1 transfer per cycle per slot.
    always_comb begin
        in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    end

    assign acc = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Per-slot next state
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            load[k]   = acc & (in_sel == 2'(k));
            take[k]   = valid_q[k] & out_ready[k];
            // A load wins over a drain in the same cycle. The slot stays
            // valid and holds the new value.
            valid_d[k] = load[k] | (valid_q[k] & ~take[k]);
            // Data is kept after a drain rather than cleared, so it changes
            // only on a load.
            data_d[k]  = load[k] ? in_data : data_q[k];
        end
    end

    always_comb begin
        cnt_d = acc ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all register-derived)
    // -----------------------------------------------------------------------
    assign out0       = data_q[0];
    assign out1       = data_q[1];
    assign out2       = data_q[2];
    assign out3       = data_q[3];
    assign out_valid  = valid_q;
    assign busy       = |valid_q;
    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux_1x4_5bit_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1x4_5bit_reg
//
// Self-checking bench for demux_1x4_5bit_reg. A behavioural model holds four
// slots as plain arrays and a wrapping counter. Each scenario task drives
// stimulus and compares the DUT against the model or against fixed values.
// ---------------------------------------------------------------------------
module tb_demux_1x4_5bit_reg;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;
    logic [CNT_W-1:0] accept_cnt;

    logic [4*WIDTH-1:0] dut_outs;
    assign dut_outs = {out3, out2, out1, out0};

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [WIDTH-1:0] m_data [4];
    logic [3:0]       m_valid;
    logic [CNT_W-1:0] m_cnt;

    demux_1x4_5bit_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .accept_cnt (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_data[k] = '0;
        m_valid = '0;
        m_cnt   = '0;
    endfunction

    function automatic logic model_ready();
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    function automatic logic [4*WIDTH-1:0] model_outs();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    // Advance the model by one edge from the current inputs, then clock the
    // DUT and settle 1 time unit past the edge.
    task automatic step();
        logic acc;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = in_valid && model_ready();
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
            end
            if (acc) begin
                m_data[in_sel]  = in_data;
                m_valid[in_sel] = 1'b1;
                m_cnt           = m_cnt + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic quick_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 4'b0000 || dut_outs !== '0 || accept_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b outs=%h cnt=%0d busy=%b, want all zero",
                     out_valid, dut_outs, accept_cnt, busy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Fill all slots, then assert reset between edges.
        for (int k = 0; k < 4; k++) send(2'(k), WIDTH'(5'h11 + k));
        checks++;
        if (out_valid !== 4'b1111) begin
            errors++;
            $display("FAIL reset_fill: valid=%b want 1111", out_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 4'b0000 || dut_outs !== '0 || accept_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b outs=%h cnt=%0d busy=%b, want all zero",
                     out_valid, dut_outs, accept_cnt, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 4'b0000 || dut_outs !== '0 || accept_cnt !== '0) begin
            errors++;
            $display("FAIL reset_release: valid=%b outs=%h cnt=%0d, want all zero",
                     out_valid, dut_outs, accept_cnt);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_routing();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 5'b00000;
        vals[1] = 5'b11001;
        vals[2] = 5'b11000;
        vals[3] = 5'b00111;
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = vals[k];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL routing_ready[%0d]: in_ready=%b want 1", k, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (dut_outs !== {5'b00111, 5'b11000, 5'b11001, 5'b00000}) begin
            errors++;
            $display("FAIL routing_data: outs=%h want %h", dut_outs,
                     {5'b00111, 5'b11000, 5'b11001, 5'b00000});
        end
        checks++;
        if (out_valid !== 4'b1111 || accept_cnt !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL routing_state: valid=%b cnt=%0d busy=%b want 1111/4/1",
                     out_valid, accept_cnt, busy);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 5'b00100;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready: in_ready=%b want 0", in_ready);
        end
        step();
        checks++;
        if (out2 !== 5'b11000 || out_valid[2] !== 1'b1 || accept_cnt !== 8'd4) begin
            errors++;
            $display("FAIL bp_stall_hold: out2=%b valid2=%b cnt=%0d want 11000/1/4",
                     out2, out_valid[2], accept_cnt);
        end
        // Empty slot 3 so the next input on sel3 can go in.
        in_valid  = 1'b0;
        out_ready = 4'b1000;
        step();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 5'b11011;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out3 !== 5'b11011 || out_valid !== 4'b1111 || out2 !== 5'b11000) begin
            errors++;
            $display("FAIL bp_other_load: out3=%b out2=%b valid=%b want 11011/11000/1111",
                     out3, out2, out_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_pass_through();
        logic [CNT_W-1:0] cnt0;
        cnt0      = m_cnt;
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL pass_ready[%0d]: in_ready=%b want 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid[3] !== 1'b1 || out3 !== 5'b11011) begin
                errors++;
                $display("FAIL pass_valid[%0d]: valid3=%b out3=%b want 1/11011",
                         i, out_valid[3], out3);
            end
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (accept_cnt !== cnt0 + 8'd3) begin
            errors++;
            $display("FAIL pass_count: cnt=%0d want %0d", accept_cnt, cnt0 + 8'd3);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_drain();
        logic [WIDTH-1:0] d [4];
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            d[k] = WIDTH'($urandom);
            send(2'(k), d[k]);
        end
        checks++;
        if (out_valid !== 4'b1111) begin
            errors++;
            $display("FAIL drain_fill: valid=%b want 1111", out_valid);
        end
        out_ready = 4'b1010;
        step();
        checks++;
        if (out_valid !== 4'b0101 || out1 !== d[1] || out3 !== d[3]) begin
            errors++;
            $display("FAIL drain_partial: valid=%b out1=%h out3=%h want 0101/%h/%h",
                     out_valid, out1, out3, d[1], d[3]);
        end
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || dut_outs !== {d[3], d[2], d[1], d[0]}) begin
            errors++;
            $display("FAIL drain_all: valid=%b busy=%b outs=%h want 0000/0/%h",
                     out_valid, busy, dut_outs, {d[3], d[2], d[1], d[0]});
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_counter_wrap();
        int stalls;
        stalls = 0;
        quick_reset();
        out_ready = 4'b1111;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'($urandom);
            in_data  = WIDTH'($urandom);
            #1;
            if (in_ready !== 1'b1) stalls++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL wrap_ready: %0d stalled cycles, want 0", stalls);
        end
        checks++;
        if (accept_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count: cnt=%0d want 1", accept_cnt);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random();
        logic pending;
        int   bad;
        bad     = 0;
        pending = 1'b0;
        quick_reset();
        for (int i = 0; i < 600 && bad < 5; i++) begin
            // A stalled producer must keep its value and select stable.
            if (!pending) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom);
                in_data  = WIDTH'($urandom);
            end
            out_ready = 4'($urandom);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                bad++;
                $display("FAIL rand_ready[%0d]: in_ready=%b want %b", i, in_ready, model_ready());
            end
            pending = in_valid && !model_ready();
            step();
            checks++;
            if (dut_outs !== model_outs() || out_valid !== m_valid || busy !== (|m_valid) ||
                accept_cnt !== m_cnt) begin
                errors++;
                bad++;
                $display("FAIL rand_state[%0d]: outs=%h valid=%b busy=%b cnt=%0d want %h/%b/%b/%0d",
                         i, dut_outs, out_valid, busy, accept_cnt, model_outs(), m_valid,
                         |m_valid, m_cnt);
            end
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_pass_through();
        test_drain();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
